// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with single-cycle multiply and 32-step restoring divide.
// Feeds MFHI/MFLO in the execute stage; busy stalls dependent instructions.
module hilo_muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(DIV_STEPS);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_LAST = CW'(DIV_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   opa_r;
    logic [WIDTH-1:0]   opb_r;
    logic [2:0]         op_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               div_zero_r;
    logic [WIDTH-1:0]   rem_r;
    logic [CW-1:0]      cnt_r;

    logic               div_sgn_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic               mul_sgn_s;
    logic [2*WIDTH-1:0] mul_a_ext_s;
    logic [2*WIDTH-1:0] mul_b_ext_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     rem_shift_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic               qbit_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    // Two's-complement negate when the operand is treated as signed and negative.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] r;
        if (sgn && v[WIDTH-1]) begin
            r = (~v) + ONE_W;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Operand magnitudes captured when a divide is accepted.
    always_comb begin
        div_sgn_s = (op == OP_DIV);
        a_mag_s   = abs_val(a, div_sgn_s);
        b_mag_s   = abs_val(b, div_sgn_s);
    end

    // Full-width product; sign-extending to 2*WIDTH makes one multiplier serve both forms.
    always_comb begin
        mul_sgn_s   = (op_r == OP_MULT);
        mul_a_ext_s = {{WIDTH{mul_sgn_s & opa_r[WIDTH-1]}}, opa_r};
        mul_b_ext_s = {{WIDTH{mul_sgn_s & opb_r[WIDTH-1]}}, opb_r};
        prod_s      = mul_a_ext_s * mul_b_ext_s;
    end

    // One restoring step: opa_r shifts the dividend out and the quotient bits in.
    always_comb begin
        rem_shift_s = {rem_r, opa_r[WIDTH-1]};
        diff_s      = rem_shift_s - {1'b0, opb_r};
        if (diff_s[WIDTH] == 1'b0) begin
            rem_next_s = diff_s[WIDTH-1:0];
            qbit_s     = 1'b1;
        end else begin
            rem_next_s = rem_shift_s[WIDTH-1:0];
            qbit_s     = 1'b0;
        end
    end

    // Sign correction; a zero divisor forces an all-ones quotient while the remainder
    // naturally reconstructs the original dividend.
    always_comb begin
        if (div_zero_r) begin
            quo_fix_s = ONES_W;
        end else if (neg_q_r) begin
            quo_fix_s = (~opa_r) + ONE_W;
        end else begin
            quo_fix_s = opa_r;
        end
        if (neg_r_r) begin
            rem_fix_s = (~rem_r) + ONE_W;
        end else begin
            rem_fix_s = rem_r;
        end
    end

    // Control FSM, datapath registers and the HI/LO pair.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            hi_r       <= ZERO_W;
            lo_r       <= ZERO_W;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            opa_r      <= ZERO_W;
            opb_r      <= ZERO_W;
            op_r       <= 3'd0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            div_zero_r <= 1'b0;
            rem_r      <= ZERO_W;
            cnt_r      <= {CW{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: hi_r <= a;
                            OP_MTLO: lo_r <= a;
                            OP_MULT, OP_MULTU: begin
                                opa_r   <= a;
                                opb_r   <= b;
                                op_r    <= op;
                                state_r <= ST_MUL;
                                busy_r  <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                opa_r      <= a_mag_s;
                                opb_r      <= b_mag_s;
                                op_r       <= op;
                                neg_q_r    <= div_sgn_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_r_r    <= div_sgn_s & a[WIDTH-1];
                                div_zero_r <= (b == ZERO_W);
                                rem_r      <= ZERO_W;
                                cnt_r      <= {CW{1'b0}};
                                state_r    <= ST_DIV;
                                busy_r     <= 1'b1;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    hi_r    <= prod_s[2*WIDTH-1:WIDTH];
                    lo_r    <= prod_s[WIDTH-1:0];
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                ST_DIV: begin
                    rem_r <= rem_next_s;
                    opa_r <= {opa_r[WIDTH-2:0], qbit_s};
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_r    <= rem_fix_s;
                    lo_r    <= quo_fix_s;
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expected {hi,lo} queued at start, checked on done.
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    logic [63:0] sb_q[$];
    logic [63:0] mon_exp;

    hilo_muldiv_unit #(.WIDTH(W), .DIV_STEPS(32)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] r;
        longint sx, sy, q, rm;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: r = sx * sy;
            3'd1: r = {32'd0, x} * {32'd0, y};
            3'd2: begin
                if (y == 32'd0) begin
                    r = {x, 32'hFFFF_FFFF};
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    r = {32'd0, 32'h8000_0000};
                end else begin
                    q  = sx / sy;
                    rm = sx % sy;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
                else            r = {x % y, x / y};
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Done monitor: every done pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    check_val("spurious_done", 64'd1, 64'd0);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check_val("hilo", {hi, lo}, mon_exp);
                end
            end
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp, input int exp_cyc);
        logic [63:0] prev;
        int cyc;
        prev = {hi, lo};
        sb_q.push_back(exp);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (cyc == 1) check_val("hold_hilo", {hi, lo}, prev);
            tick();
        end
        check_val("busy_cycles", 64'(cyc), 64'(exp_cyc));
        check_val("done_pulse", {63'd0, done}, 64'd1);
    endtask

    initial begin
        int bcnt;
        int dbefore;
        logic [2:0] ro;
        logic [31:0] ra, rb;

        reset_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        tick(); tick();
        check_val("rst_hi", {32'd0, hi}, 64'd0);
        check_val("rst_lo", {32'd0, lo}, 64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        reset_n = 1'b1;
        tick();

        // Directed cases, issued back to back so start coincides with done.
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3,           {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 1);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,   {32'hFFFF_FFFE, 32'h0000_0001}, 1);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2,           {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_op(3'd3, 32'd100,       32'd7,           {32'd2,         32'd14},        33);
        run_op(3'd3, 32'd5,         32'd0,           {32'd5,         32'hFFFF_FFFF}, 33);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF,   {32'd0,         32'h8000_0000}, 33);
        run_op(3'd2, 32'd7,         32'hFFFF_FFFE,   {32'd1,         32'hFFFF_FFFD}, 33);
        run_op(3'd2, 32'hFFFF_FFF7, 32'd0,           {32'hFFFF_FFF7, 32'hFFFF_FFFF}, 33);

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            run_op(ro, ra, rb, model(ro, ra, rb), (ro < 3'd2) ? 1 : 33);
        end
        tick();
        check_val("sb_drain", 64'(sb_q.size()), 64'd0);

        // MTHI then MTLO on consecutive edges.
        op = 3'd4; a = 32'h0000_1234; start = 1'b1;
        tick();
        check_val("mthi_hi", {32'd0, hi}, 64'h1234);
        check_val("mthi_busy", {63'd0, busy}, 64'd0);
        op = 3'd5; a = 32'h0000_5678;
        tick();
        start = 1'b0;
        check_val("mtlo_hilo", {hi, lo}, {32'h1234, 32'h5678});
        check_val("mtlo_busy", {63'd0, busy}, 64'd0);
        tick();
        check_val("mt_nodone", {63'd0, done}, 64'd0);

        // Reserved op code has no effect.
        op = 3'd6; a = 32'hDEAD_BEEF; b = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("op6_hilo", {hi, lo}, {32'h1234, 32'h5678});
        tick();
        check_val("op6_busy", {63'd0, busy}, 64'd0);

        // DIV in flight: ignored MULT request, then reset aborts it.
        dbefore = done_cnt;
        op = 3'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        op = 3'd0; a = 32'd2; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("ign_busy", {63'd0, busy}, 64'd1);
        check_val("ign_hilo", {hi, lo}, {32'h1234, 32'h5678});
        for (int i = 0; i < 9; i++) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_val("abort_hilo", {hi, lo}, 64'd0);
        check_val("abort_busy", {63'd0, busy}, 64'd0);
        check_val("abort_done", {63'd0, done}, 64'd0);
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy === 1'b1) bcnt++;
        end
        check_val("abort_quiet", 64'(bcnt), 64'd0);
        check_val("abort_nodone", 64'(done_cnt), 64'(dbefore));

        // Recovery after the aborted divide.
        run_op(3'd3, 32'hFFFF_FFFF, 32'd10, {32'd5, 32'h1999_9999}, 33);
        tick();
        check_val("sb_final", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
